// File: rtl/mor1kx_branch_resolve_unit_if.sv
// Interface bundling the decode-side branch inputs, the flag/flush controls,
// the fetch redirect handshake and the feedback/statistics outputs of
// mor1kx_branch_resolve_unit.
//   master : pipeline / fetch side (drives *_i, observes *_o)
//   slave  : the branch resolve unit itself
// Parameters:
//   OPTION_OPERAND_WIDTH  PC / target width
//   CNT_WIDTH             width of the statistic counters
interface mor1kx_branch_resolve_unit_if #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int CNT_WIDTH            = 16
);
  logic                            padv_decode_i;
  logic                            pipeline_flush_i;
  logic                            decode_op_bf_i;
  logic                            decode_op_bnf_i;
  logic                            decode_pred_flag_i;
  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i;
  logic [OPTION_OPERAND_WIDTH-1:0] decode_target_i;
  logic                            flag_i;
  logic                            redirect_ack_i;

  logic                            execute_op_bf_o;
  logic                            execute_op_bnf_o;
  logic                            prev_op_brcond_o;
  logic                            branch_mispredict_o;
  logic                            redirect_valid_o;
  logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o;
  logic [CNT_WIDTH-1:0]            branch_cnt_o;
  logic [CNT_WIDTH-1:0]            mispredict_cnt_o;

  modport master (
    output padv_decode_i, pipeline_flush_i, decode_op_bf_i, decode_op_bnf_i,
           decode_pred_flag_i, decode_pc_i, decode_target_i, flag_i,
           redirect_ack_i,
    input  execute_op_bf_o, execute_op_bnf_o, prev_op_brcond_o,
           branch_mispredict_o, redirect_valid_o, redirect_pc_o,
           branch_cnt_o, mispredict_cnt_o
  );

  modport slave (
    input  padv_decode_i, pipeline_flush_i, decode_op_bf_i, decode_op_bnf_i,
           decode_pred_flag_i, decode_pc_i, decode_target_i, flag_i,
           redirect_ack_i,
    output execute_op_bf_o, execute_op_bnf_o, prev_op_brcond_o,
           branch_mispredict_o, redirect_valid_o, redirect_pc_o,
           branch_cnt_o, mispredict_cnt_o
  );
endinterface

// File: rtl/mor1kx_branch_resolve_unit.sv
// Execute-stage consumer of the gshare predictor's decode-stage output.
// Registers each decoded l.bf / l.bnf together with its predicted flag,
// resolves it against SR[F] in execute, feeds the outcome back to the
// predictor, raises a held redirect request to fetch on a mispredict and
// keeps saturating branch / mispredict statistics.
// Ports:
//   clk   clock
//   rst   synchronous, active-high reset
//   bus   slave modport of mor1kx_branch_resolve_unit_if:
//         decode inputs (padv, flush, bf/bnf, predicted flag, pc, target),
//         flag_i, redirect_ack_i in; execute_op_bf/bnf, prev_op_brcond,
//         branch_mispredict (combinational), redirect_valid/pc and the
//         branch/mispredict counters out.
module mor1kx_branch_resolve_unit #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  mor1kx_branch_resolve_unit_if.slave bus
);

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } state_t;

  state_t                          state;

  logic                            ex_bf;
  logic                            ex_bnf;
  logic                            ex_pred;
  logic [OPTION_OPERAND_WIDTH-1:0] ex_pc;
  logic [OPTION_OPERAND_WIDTH-1:0] ex_tgt;

  logic                            redirect_valid;
  logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc;
  logic [CNT_WIDTH-1:0]            branch_cnt;
  logic [CNT_WIDTH-1:0]            mispredict_cnt;

  logic                            brcond;
  logic                            taken;
  logic                            mispredict;
  logic                            resolve_event;
  logic                            mispredict_event;
  logic [OPTION_OPERAND_WIDTH-1:0] fallthrough_pc;

  assign brcond = ex_bf | ex_bnf;
  assign taken  = (ex_bf & bus.flag_i) | (ex_bnf & ~bus.flag_i);

  // Mispredicts are masked while a redirect is still outstanding so the
  // first one wins and later ones are neither redirected nor counted.
  assign mispredict = brcond & (taken != ex_pred) & (state == IDLE);

  // A branch resolves on the cycle it leaves execute, the same qualifier
  // the predictor uses, so a stalled branch is counted exactly once.
  assign resolve_event    = brcond & bus.padv_decode_i;
  assign mispredict_event = resolve_event & mispredict;

  // Not-taken path skips the delay slot; wraps modulo 2^W.
  assign fallthrough_pc = ex_pc + OPTION_OPERAND_WIDTH'(8);

  assign bus.execute_op_bf_o     = ex_bf;
  assign bus.execute_op_bnf_o    = ex_bnf;
  assign bus.prev_op_brcond_o    = brcond;
  assign bus.branch_mispredict_o = mispredict;
  assign bus.redirect_valid_o    = redirect_valid;
  assign bus.redirect_pc_o       = redirect_pc;
  assign bus.branch_cnt_o        = branch_cnt;
  assign bus.mispredict_cnt_o    = mispredict_cnt;

  // Flush wins over advance and only needs to kill the branch markers;
  // the remaining fields are meaningless without them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_bf   <= 1'b0;
      ex_bnf  <= 1'b0;
      ex_pred <= 1'b0;
      ex_pc   <= '0;
      ex_tgt  <= '0;
    end else if (bus.pipeline_flush_i) begin
      ex_bf  <= 1'b0;
      ex_bnf <= 1'b0;
    end else if (bus.padv_decode_i) begin
      ex_bf   <= bus.decode_op_bf_i;
      ex_bnf  <= bus.decode_op_bnf_i;
      ex_pred <= bus.decode_pred_flag_i;
      ex_pc   <= bus.decode_pc_i;
      ex_tgt  <= bus.decode_target_i;
    end
  end

  // Redirect FSM: the redirect PC is captured at the mispredict so it stays
  // stable while fetch takes its time to acknowledge. A pipeline flush does
  // not cancel an outstanding redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mispredict_event) begin
            state          <= WAIT_ACK;
            redirect_valid <= 1'b1;
            redirect_pc    <= taken ? ex_tgt : fallthrough_pc;
          end
        end
        WAIT_ACK: begin
          if (bus.redirect_ack_i) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (resolve_event) begin
      if (branch_cnt != '1)
        branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      if (mispredict && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_mor1kx_branch_resolve_unit.sv
// Self-checking bench for mor1kx_branch_resolve_unit. Two instances share one
// stimulus stream: a 16-bit-counter unit and a 2-bit-counter unit, so the
// saturation behaviour is exercised alongside normal operation.
module tb_mor1kx_branch_resolve_unit;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         padv;
  logic         flush;
  logic         dbf;
  logic         dbnf;
  logic         dpred;
  logic         flag;
  logic         ack;
  logic [W-1:0] dpc;
  logic [W-1:0] dtgt;

  mor1kx_branch_resolve_unit_if #(.OPTION_OPERAND_WIDTH(W), .CNT_WIDTH(16)) bus16 ();
  mor1kx_branch_resolve_unit_if #(.OPTION_OPERAND_WIDTH(W), .CNT_WIDTH(2))  bus2 ();

  assign bus16.padv_decode_i      = padv;
  assign bus16.pipeline_flush_i   = flush;
  assign bus16.decode_op_bf_i     = dbf;
  assign bus16.decode_op_bnf_i    = dbnf;
  assign bus16.decode_pred_flag_i = dpred;
  assign bus16.decode_pc_i        = dpc;
  assign bus16.decode_target_i    = dtgt;
  assign bus16.flag_i             = flag;
  assign bus16.redirect_ack_i     = ack;

  assign bus2.padv_decode_i       = padv;
  assign bus2.pipeline_flush_i    = flush;
  assign bus2.decode_op_bf_i      = dbf;
  assign bus2.decode_op_bnf_i     = dbnf;
  assign bus2.decode_pred_flag_i  = dpred;
  assign bus2.decode_pc_i         = dpc;
  assign bus2.decode_target_i     = dtgt;
  assign bus2.flag_i              = flag;
  assign bus2.redirect_ack_i      = ack;

  mor1kx_branch_resolve_unit #(.OPTION_OPERAND_WIDTH(W), .CNT_WIDTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  mor1kx_branch_resolve_unit #(.OPTION_OPERAND_WIDTH(W), .CNT_WIDTH(2)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the instruction sitting in execute, whether a redirect
  // is outstanding and its PC, and unbounded event counts.
  logic         m_bf   = 1'b0;
  logic         m_bnf  = 1'b0;
  logic         m_pred = 1'b0;
  logic         m_wait = 1'b0;
  logic [W-1:0] m_pc   = '0;
  logic [W-1:0] m_tgt  = '0;
  logic [W-1:0] m_rpc  = '0;
  longint       m_bcnt = 0;
  longint       m_mcnt = 0;

  function automatic longint sat(input longint v, input int width);
    longint maxv;
    maxv = (longint'(1) << width) - 1;
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both units against the model for the current cycle, then step
  // the model across the coming clock edge.
  task automatic checkOutput();
    logic brcond;
    logic taken;
    logic mis;
    brcond = m_bf | m_bnf;
    taken  = m_bf ? flag : (m_bnf ? ~flag : 1'b0);
    mis    = brcond && (taken != m_pred) && !m_wait;

    compare("ex_bf",       bus16.execute_op_bf_o,     m_bf);
    compare("ex_bnf",      bus16.execute_op_bnf_o,    m_bnf);
    compare("brcond",      bus16.prev_op_brcond_o,    brcond);
    compare("mispredict",  bus16.branch_mispredict_o, mis);
    compare("rvalid",      bus16.redirect_valid_o,    m_wait);
    if (m_wait) compare("rpc", bus16.redirect_pc_o,   m_rpc);
    compare("bcnt16",      bus16.branch_cnt_o,        sat(m_bcnt, 16));
    compare("mcnt16",      bus16.mispredict_cnt_o,    sat(m_mcnt, 16));
    compare("sat mispredict", bus2.branch_mispredict_o, mis);
    compare("sat rvalid",  bus2.redirect_valid_o,     m_wait);
    if (m_wait) compare("sat rpc", bus2.redirect_pc_o, m_rpc);
    compare("bcnt2",       bus2.branch_cnt_o,         sat(m_bcnt, 2));
    compare("mcnt2",       bus2.mispredict_cnt_o,     sat(m_mcnt, 2));

    if (rst) begin
      m_bf = 0; m_bnf = 0; m_pred = 0; m_wait = 0;
      m_pc = '0; m_tgt = '0; m_rpc = '0; m_bcnt = 0; m_mcnt = 0;
    end else begin
      if (m_wait) begin
        if (ack) m_wait = 1'b0;
      end else if (mis && padv) begin
        m_wait = 1'b1;
        m_rpc  = taken ? m_tgt : m_pc + 32'd8;
      end
      if (brcond && padv) begin
        m_bcnt++;
        if (mis) m_mcnt++;
      end
      if (flush) begin
        m_bf = 0; m_bnf = 0;
      end else if (padv) begin
        m_bf = dbf; m_bnf = dbnf; m_pred = dpred; m_pc = dpc; m_tgt = dtgt;
      end
    end
  endtask

  // op: 0 = no branch, 1 = l.bf, 2 = l.bnf in decode.
  task automatic applyStimulus(input logic r, input logic pv, input logic fl,
                               input int op, input logic pred,
                               input logic [W-1:0] pc, input logic [W-1:0] tgt,
                               input logic f, input logic a);
    @(negedge clk);
    rst = r; padv = pv; flush = fl;
    dbf = (op == 1); dbnf = (op == 2);
    dpred = pred; dpc = pc; dtgt = tgt; flag = f; ack = a;
    #1;
    checkOutput();
  endtask

  task automatic loadBranch(input int op, input logic pred, input logic [W-1:0] pc, input logic [W-1:0] tgt);
    applyStimulus(0, 1, 0, op, pred, pc, tgt, 0, 0);
  endtask

  task automatic resolveBranch(input logic f);
    applyStimulus(0, 1, 0, 0, 0, '0, '0, f, 0);
  endtask

  task automatic idle(input logic a);
    applyStimulus(0, 0, 0, 0, 0, '0, '0, 0, a);
  endtask

  initial begin
    int valid_cycles;
    logic [W-1:0] rpc;
    int op;

    rst = 1; padv = 0; flush = 0; dbf = 0; dbnf = 0; dpred = 0;
    dpc = '0; dtgt = '0; flag = 0; ack = 0;
    repeat (3) @(posedge clk);

    idle(0);
    compare("reset rvalid", bus16.redirect_valid_o, 0);
    compare("reset rpc",    bus16.redirect_pc_o,    0);
    compare("reset brcond", bus16.prev_op_brcond_o, 0);
    compare("reset bcnt",   bus16.branch_cnt_o,     0);
    compare("reset mcnt",   bus16.mispredict_cnt_o, 0);

    // Correctly predicted l.bf.
    loadBranch(1, 1, 32'h10, 32'h20);
    resolveBranch(1);
    compare("T1 mispredict", bus16.branch_mispredict_o, 0);
    idle(0);
    compare("T1 bcnt", bus16.branch_cnt_o, 1);
    compare("T1 mcnt", bus16.mispredict_cnt_o, 0);

    // l.bnf predicted taken with flag set: falls through past delay slot.
    loadBranch(2, 1, 32'h100, 32'h200);
    resolveBranch(1);
    compare("T2 mispredict", bus16.branch_mispredict_o, 1);
    idle(0);
    compare("T2 rvalid", bus16.redirect_valid_o, 1);
    compare("T2 rpc",    bus16.redirect_pc_o,    32'h108);
    idle(1);
    idle(0);

    // Taken l.bf predicted not-taken, ack on the third redirect cycle.
    loadBranch(1, 0, 32'h300, 32'h400);
    resolveBranch(1);
    valid_cycles = 0;
    idle(0); valid_cycles += int'(bus16.redirect_valid_o); rpc = bus16.redirect_pc_o;
    idle(0); valid_cycles += int'(bus16.redirect_valid_o);
    idle(1); valid_cycles += int'(bus16.redirect_valid_o);
    idle(0); valid_cycles += int'(bus16.redirect_valid_o);
    compare("T3 valid cycles", valid_cycles, 3);
    compare("T3 rpc", rpc, 32'h400);

    // Fall-through PC wraps past the top of the address space.
    loadBranch(1, 1, 32'hFFFF_FFFC, 32'h800);
    resolveBranch(0);
    idle(0);
    compare("T4 rpc wrap", bus16.redirect_pc_o, 32'h4);
    idle(1);
    idle(0);

    // Flush in the same cycle as the advance kills the branch.
    applyStimulus(0, 1, 1, 1, 0, 32'h500, 32'h600, 0, 0);
    resolveBranch(1);
    compare("T5 brcond", bus16.prev_op_brcond_o, 0);
    idle(0);
    compare("T5 rvalid", bus16.redirect_valid_o, 0);
    compare("T5 bcnt",   bus16.branch_cnt_o, 4);

    // Two more mispredicts: five in total, 2-bit counters pinned at 3.
    for (int k = 0; k < 2; k++) begin
      loadBranch(2, 0, 32'h700, 32'h900);
      resolveBranch(0);
      idle(1);
      idle(0);
    end
    compare("T6 bcnt16", bus16.branch_cnt_o, 6);
    compare("T6 mcnt16", bus16.mispredict_cnt_o, 5);
    compare("T6 bcnt2",  bus2.branch_cnt_o, 3);
    compare("T6 mcnt2",  bus2.mispredict_cnt_o, 3);

    // Reset while a redirect is outstanding drops it.
    loadBranch(1, 0, 32'hA00, 32'hB00);
    resolveBranch(1);
    idle(0);
    compare("T7 rvalid before rst", bus16.redirect_valid_o, 1);
    applyStimulus(1, 0, 0, 0, 0, '0, '0, 0, 0);
    idle(0);
    compare("T7 rvalid after rst", bus16.redirect_valid_o, 0);

    // Randomized traffic, including stalls, flushes, late acks and resets.
    for (int i = 0; i < 4000; i++) begin
      op  = $urandom_range(0, 2);
      rpc = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
      applyStimulus($urandom_range(0, 299) == 0,
                    $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) == 0,
                    op,
                    1'($urandom_range(0, 1)),
                    rpc,
                    $urandom() & 32'hFFFF_FFFC,
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 9) < 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
